ly_one_shot_gen: RTL and testbench
==================================

Name: ly_one_shot_gen

Overview:
- Parametrised, per-channel one-shot for a full layer of wire-group hits.
- Each channel's rising edge yields an output pulse of programmable width, then a programmable dead time.
- Adds an optional retrigger mode, a per-channel mask and a trig_stop freeze.
- Sits between the input hit synchroniser and the pattern finder; replaces fixed 64-channel one-shot layers.

Parameters:
NCH, 64, number of channels in the layer
PW_BITS, 4, width of pulse-width setting (pulse 1..2^PW_BITS-1 cycles)
DT_BITS, 4, width of dead-time setting (0..2^DT_BITS-1 cycles)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ly  input  NCH  raw layer hits, already synchronous to clk
lyr  output  NCH  one-shot outputs, registered
trig_stop  input  1  freeze: hold all channel states and outputs
pulse_width  input  PW_BITS  pulse length in cycles; 0 treated as 1
dead_time  input  DT_BITS  dead cycles after pulse; 0 = none
retrig  input  1  1 = edge during PULSE reloads pulse counter
mask  input  NCH  1 = channel disabled
any_start  output  1  registered: some channel entered PULSE this cycle

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: lyr=0, any_start=0, all channels IDLE, counters 0, edge history ly_q=all ones, so inputs held high through reset do not fire.
- ly_q<=ly every cycle, including during trig_stop; edge[i] = ly[i] & ~ly_q[i].
- Per channel FSM, states IDLE, PULSE, DEAD; lyr[i]=1 only in PULSE.
- IDLE: edge & ~mask & ~trig_stop -> PULSE.
  - Load pcnt = max(pulse_width,1).
  - lyr rises on the same clock edge that samples ly high: 1-cycle latency.
- PULSE: pcnt decrements each cycle.
  - When pcnt==1 at a clock edge: if dead_time!=0, go to DEAD with dcnt=dead_time; else go to IDLE.
  - Result: lyr stays high for exactly max(pulse_width,1) cycles.
- PULSE with retrig=1 and edge: reload pcnt=max(pulse_width,1). Reload beats expiry when both occur on the same edge.
- PULSE with retrig=0: edges ignored.
- DEAD: dcnt decrements; at dcnt==1 go to IDLE. Edges in DEAD, including on the final DEAD cycle, are discarded.
  - Minimum spacing between pulse starts = width + dead + 1 cycles.
- pulse_width is captured only at load; dead_time only at DEAD entry. Mid-operation changes affect only the next pulse.
- mask[i]=1: channel forced to IDLE at the next edge (aborts PULSE/DEAD), so lyr[i]=0 one cycle later. Unmasking does not fire on an already-high input unless a fresh edge occurs.
- trig_stop=1: all states, counters and lyr frozen; edges occurring during it are discarded, not queued. Release resumes from the frozen state with no lost or extra cycles.
- Precedence: rst > mask > trig_stop > normal FSM.
- any_start = registered OR over channels of the IDLE->PULSE transition. A retrigger reload does not set it.
- All channels are independent; no cross-channel logic other than the any_start OR.
- Counters saturate-safe: never wrap below 1 in PULSE/DEAD.

Test Plan:
- Single hit: pulse_width=3, dead_time=2, retrig=0; ly[5] high from cycle 10 for 8 cycles.
  -> lyr[5]=1 cycles 10..12; no other pulse; any_start=1 at cycle 10 only.
- Dead-time rejection: same settings; ly[7] edges at cycles 0, 4, 6.
  -> pulses start at 0 and 6 only; the cycle-4 edge falls on the final DEAD cycle and is discarded.
- Retrigger: pulse_width=4, dead_time=0, retrig=1; edges ch0 at cycles 0 and 2.
  -> lyr[0]=1 cycles 0..5; any_start pulses only at cycle 0.
- trig_stop freeze: pulse_width=5; edge ch3 at cycle 0, trig_stop high cycles 2..6, extra edge ch3 at cycle 4.
  -> lyr[3]=1 for cycles 0..1 and 2..6 (held), then 7..9; total 5 counting cycles; cycle-4 edge produces no pulse.
- Mask and reset: mask[9] asserted at cycle 1 of a width-6 pulse -> lyr[9]=0 from cycle 2. Separately, rst released with ly=all ones -> lyr stays 0 until an input falls and rises again.
- Width boundary: pulse_width=0 -> 1-cycle pulse; pulse_width=15, dead_time=15, all 64 channels hit simultaneously -> every lyr bit is high for exactly 15 cycles.

Source files
------------

// File: rtl/ly_one_shot_gen.sv
// Per-channel one-shot for one layer of wire-group hits.
// A rising edge on a channel starts an output pulse of programmable width, followed by a
// programmable dead time during which further edges are discarded. The layer also supports
// retriggering during a pulse, a per-channel mask and a global trig_stop freeze.
module ly_one_shot_gen #(
    parameter int unsigned NCH     = 64,
    parameter int unsigned PW_BITS = 4,
    parameter int unsigned DT_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     ly,
    output logic [NCH-1:0]     lyr,
    input  logic               trig_stop,
    input  logic [PW_BITS-1:0] pulse_width,
    input  logic [DT_BITS-1:0] dead_time,
    input  logic               retrig,
    input  logic [NCH-1:0]     mask,
    output logic               any_start
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StDead  = 2'd2
    } ch_state_e;

    localparam logic [PW_BITS-1:0] PwOne = PW_BITS'(1);
    localparam logic [DT_BITS-1:0] DtOne = DT_BITS'(1);

    ch_state_e          state_q [NCH];
    ch_state_e          state_d [NCH];
    logic [PW_BITS-1:0] pcnt_q  [NCH];
    logic [PW_BITS-1:0] pcnt_d  [NCH];
    logic [DT_BITS-1:0] dcnt_q  [NCH];
    logic [DT_BITS-1:0] dcnt_d  [NCH];

    logic [NCH-1:0]     ly_q;
    logic [NCH-1:0]     rise;
    logic [NCH-1:0]     start_d;
    logic [NCH-1:0]     lyr_d;
    logic [NCH-1:0]     lyr_q;
    logic               any_start_q;
    logic [PW_BITS-1:0] pw_eff;

    // Effective pulse width: a zero setting still yields a single-cycle pulse.
    always_comb begin
        pw_eff = (pulse_width == '0) ? PwOne : pulse_width;
    end

    // Rising-edge detect against the previous cycle's input sample.
    always_comb begin
        rise = ly & ~ly_q;
    end

    // Per-channel next-state: mask beats trig_stop, trig_stop beats the normal FSM.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            pcnt_d[i]  = pcnt_q[i];
            dcnt_d[i]  = dcnt_q[i];
            start_d[i] = 1'b0;

            if (mask[i]) begin
                // Masking aborts whatever the channel was doing.
                state_d[i] = StIdle;
                pcnt_d[i]  = '0;
                dcnt_d[i]  = '0;
            end else if (!trig_stop) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (rise[i]) begin
                            state_d[i] = StPulse;
                            pcnt_d[i]  = pw_eff;
                            start_d[i] = 1'b1;
                        end
                    end
                    StPulse: begin
                        if (retrig && rise[i]) begin
                            // Reload wins over expiry on the same edge.
                            pcnt_d[i] = pw_eff;
                        end else if (pcnt_q[i] <= PwOne) begin
                            pcnt_d[i] = '0;
                            if (dead_time != '0) begin
                                state_d[i] = StDead;
                                dcnt_d[i]  = dead_time;
                            end else begin
                                state_d[i] = StIdle;
                            end
                        end else begin
                            pcnt_d[i] = pcnt_q[i] - PwOne;
                        end
                    end
                    StDead: begin
                        // Edges seen here are dropped, including on the last dead cycle.
                        if (dcnt_q[i] <= DtOne) begin
                            state_d[i] = StIdle;
                            dcnt_d[i]  = '0;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - DtOne;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        pcnt_d[i]  = '0;
                        dcnt_d[i]  = '0;
                    end
                endcase
            end

            lyr_d[i] = (state_d[i] == StPulse);
        end
    end

    // State, counters, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // History starts all-ones so inputs held high through reset do not fire.
            ly_q        <= '1;
            lyr_q       <= '0;
            any_start_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= StIdle;
                pcnt_q[i]  <= '0;
                dcnt_q[i]  <= '0;
            end
        end else begin
            // History tracks the input even while frozen, so frozen edges are lost.
            ly_q        <= ly;
            lyr_q       <= lyr_d;
            any_start_q <= |start_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                pcnt_q[i]  <= pcnt_d[i];
                dcnt_q[i]  <= dcnt_d[i];
            end
        end
    end

    assign lyr       = lyr_q;
    assign any_start = any_start_q;

endmodule

// File: tb/tb_ly_one_shot_gen.sv
// Self-checking bench for ly_one_shot_gen. Each test drives a short cycle-indexed stimulus,
// pushes the expected {lyr, any_start} for that cycle onto a scoreboard, then pops and
// compares it one time unit after the sampling clock edge.
module tb_ly_one_shot_gen;

    localparam int NCH = 64;

    typedef struct packed {
        logic [NCH-1:0] lyr;
        logic           any;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ly;
    logic [NCH-1:0] lyr;
    logic           trig_stop;
    logic [3:0]     pulse_width;
    logic [3:0]     dead_time;
    logic           retrig;
    logic [NCH-1:0] mask;
    logic           any_start;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ly_one_shot_gen #(
        .NCH     (NCH),
        .PW_BITS (4),
        .DT_BITS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ly          (ly),
        .lyr         (lyr),
        .trig_stop   (trig_stop),
        .pulse_width (pulse_width),
        .dead_time   (dead_time),
        .retrig      (retrig),
        .mask        (mask),
        .any_start   (any_start)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return all channels to a quiet IDLE state between tests.
    task automatic settle(input int n);
        ly        = '0;
        mask      = '0;
        trig_stop = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        pulse_width = 4'd2;
        dead_time   = 4'd0;
        retrig      = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            rst = (c < 4);
            ly  = (c == 8) ? '0 : '1;
            e.lyr = (c >= 9 && c <= 10) ? '1 : '0;
            e.any = (c == 9);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL reset cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
    endtask

    task automatic test_single_hit();
        exp_t e;
        exp_t got;
        pulse_width = 4'd3;
        dead_time   = 4'd2;
        retrig      = 1'b0;
        for (int c = 0; c <= 19; c++) begin
            ly = '0;
            if (c >= 10 && c <= 17) ly[5] = 1'b1;
            // Width change mid-pulse must not affect the running pulse.
            if (c == 11) pulse_width = 4'd7;
            e.lyr = '0;
            if (c >= 10 && c <= 12) e.lyr[5] = 1'b1;
            e.any = (c == 10);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL single_hit cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
    endtask

    task automatic test_dead_time();
        exp_t e;
        exp_t got;
        pulse_width = 4'd3;
        dead_time   = 4'd2;
        retrig      = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            ly = '0;
            if (c == 0 || c == 4 || c == 6) ly[7] = 1'b1;
            e.lyr = '0;
            if ((c >= 0 && c <= 2) || (c >= 6 && c <= 8)) e.lyr[7] = 1'b1;
            e.any = (c == 0 || c == 6);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL dead_time cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
    endtask

    // Same edge pattern with retrig on (pulse extended) and off (second edge ignored).
    task automatic test_retrigger(input logic rt);
        exp_t e;
        exp_t got;
        pulse_width = 4'd4;
        dead_time   = 4'd0;
        retrig      = rt;
        for (int c = 0; c <= 9; c++) begin
            ly = '0;
            if (c == 0 || c == 2) ly[0] = 1'b1;
            e.lyr = '0;
            if (c <= (rt ? 5 : 3)) e.lyr[0] = 1'b1;
            e.any = (c == 0);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL retrig%0b cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         rt, c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
        retrig = 1'b0;
    endtask

    task automatic test_trig_stop();
        exp_t e;
        exp_t got;
        pulse_width = 4'd5;
        dead_time   = 4'd0;
        retrig      = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            ly = '0;
            if (c == 0 || (c >= 4 && c <= 12)) ly[3] = 1'b1;
            trig_stop = (c >= 2 && c <= 6);
            e.lyr = '0;
            if (c <= 9) e.lyr[3] = 1'b1;
            e.any = (c == 0);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL trig_stop cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
        trig_stop = 1'b0;
    endtask

    task automatic test_mask();
        exp_t e;
        exp_t got;
        pulse_width = 4'd6;
        dead_time   = 4'd0;
        retrig      = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            ly   = '0;
            mask = '0;
            if (c <= 6 || c >= 8) ly[9] = 1'b1;
            if (c >= 2 && c <= 4) mask[9] = 1'b1;
            // Edge on a masked channel must not fire.
            if (c == 3) ly[11] = 1'b1;
            if (c >= 2 && c <= 4) mask[11] = 1'b1;
            e.lyr = '0;
            if (c <= 1 || (c >= 8 && c <= 13)) e.lyr[9] = 1'b1;
            e.any = (c == 0 || c == 8);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL mask cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
        mask = '0;
    endtask

    task automatic test_width_bounds();
        exp_t e;
        exp_t got;
        pulse_width = 4'd0;
        dead_time   = 4'd0;
        retrig      = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            ly = '0;
            if (c == 0) ly[20] = 1'b1;
            e.lyr = '0;
            if (c == 0) e.lyr[20] = 1'b1;
            e.any = (c == 0);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL width_min cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
        pulse_width = 4'd15;
        dead_time   = 4'd15;
        for (int c = 0; c <= 34; c++) begin
            ly    = '1;
            e.lyr = (c <= 14) ? '1 : '0;
            e.any = (c == 0);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            n_checks++;
            if (lyr !== got.lyr || any_start !== got.any)
                $display("FAIL width_max cyc %0d: lyr=%h any_start=%b, expected lyr=%h any_start=%b",
                         c, lyr, any_start, got.lyr, got.any);
            else
                n_pass++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        ly          = '1;
        trig_stop   = 1'b0;
        pulse_width = 4'd1;
        dead_time   = 4'd0;
        retrig      = 1'b0;
        mask        = '0;

        test_reset();
        settle(40);
        test_single_hit();
        settle(40);
        test_dead_time();
        settle(40);
        test_retrigger(1'b1);
        settle(40);
        test_retrigger(1'b0);
        settle(40);
        test_trig_stop();
        settle(40);
        test_mask();
        settle(40);
        test_width_bounds();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
